// File: rtl/sha_w_schedule.sv
// sha_w_schedule: streams SHA-2 schedule words W[0..ROUNDS-1] from a 16-word block via a sliding window
// Ports: clk; reset_n (sync, active-low); blk_valid/blk_ready/block_in load a block (W[0] in top bits);
//        w_valid/w_ready/w_out/w_round/w_last stream one word per transfer, w_last marks t == ROUNDS-1.
// Option: SHA_W_SCHEDULE_SCRUB_EN zeroes the window on the last transfer so no message data lingers in IDLE.
module sha_w_schedule #(
  parameter int WORD_BITS = 32,
  parameter int ROUNDS = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    blk_valid,
  output logic                    blk_ready,
  input  logic [16*WORD_BITS-1:0] block_in,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic [WORD_BITS-1:0]    w_out,
  output logic [6:0]              w_round,
  output logic                    w_last
);
  typedef enum logic {IDLE, RUN} state_t;
`ifdef SHA_W_SCHEDULE_SCRUB_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif
  state_t state_q, state_d;
  logic [WORD_BITS-1:0] win [16];
  logic [6:0] t;
  logic xfer, load;
  logic [WORD_BITS-1:0] w_next;
  function automatic logic [WORD_BITS-1:0] rotr(input logic [WORD_BITS-1:0] x, input int n);
    return (x >> n) | (x << (WORD_BITS - n));
  endfunction
  function automatic logic [WORD_BITS-1:0] ssig0(input logic [WORD_BITS-1:0] x);
    return WORD_BITS == 32 ? rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3) : rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
  endfunction
  function automatic logic [WORD_BITS-1:0] ssig1(input logic [WORD_BITS-1:0] x);
    return WORD_BITS == 32 ? rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10) : rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction
  assign blk_ready = state_q == IDLE;
  assign w_valid = state_q == RUN;
  assign w_out = win[0];
  assign w_round = t;
  assign w_last = w_valid && t == 7'(ROUNDS - 1);
  assign load = blk_ready && blk_valid;
  assign xfer = w_valid && w_ready;
  // window[i] holds W[t+i], so W[t+16] draws on W[t+14], W[t+9], W[t+1], W[t]
  assign w_next = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
  always_comb state_d = load ? RUN : (xfer && w_last) ? IDLE : state_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      t <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        t <= '0;
        for (int i = 0; i < 16; i++) win[i] <= block_in[(15-i)*WORD_BITS +: WORD_BITS];
      end else if (xfer) begin
        t <= w_last ? '0 : t + 7'd1;
        for (int i = 0; i < 15; i++) win[i] <= (SCRUB && w_last) ? '0 : win[i+1];
        win[15] <= (SCRUB && w_last) ? '0 : w_next;
      end
    end
  end
endmodule

// File: doc/sha_w_schedule.md
# sha_w_schedule

Sequential SHA-2 message-schedule generator: accepts one 16-word padded message block and streams W[0]..W[ROUNDS-1] one word per cycle to the compression rounds over a valid/ready handshake. It keeps a 16-word sliding window and computes W[t+16] on the fly using the standard SSIG0/SSIG1 expansion. It sits between block padding/loading and the round core. It replaces the purely combinational expansion step with a parametrised, backpressure-aware stream supporting SHA-256 and SHA-512 word sizes.

## Interface
- WORD_BITS, 32, word width; legal values 32 (SHA-224/256) and 64 (SHA-384/512).
- ROUNDS, 64, words emitted per block; 64 for WORD_BITS=32, 80 for WORD_BITS=64; legal range 16..127.
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  synchronous active-low reset.
- blk_valid  in  1  block_in is valid.
- blk_ready  out  1  block can be accepted; high only in IDLE.
- block_in  in  16*WORD_BITS  message block; W[0] in the top WORD_BITS bits, W[15] in the bottom WORD_BITS bits.
- w_valid  out  1  w_out holds a valid schedule word.
- w_ready  in  1  downstream accepts w_out.
- w_out  out  WORD_BITS  current W[t].
- w_round  out  7  current t.
- w_last  out  1  high when w_valid and t == ROUNDS-1.

## Operation
- States: IDLE, RUN.
- IDLE: blk_ready=1, w_valid=0. On blk_valid: load window[0..15] = W[0..15], t=0, go to RUN.
- RUN: blk_ready=0, w_valid=1, w_out=window[0], w_round=t.
- A transfer occurs on w_valid && w_ready:
  - window[i] <= window[i+1] for i=0..14.
  - window[15] <= SSIG1(window[14]) + window[9] + SSIG0(window[1]) + window[0], i.e. W[t+16], computed mod 2^WORD_BITS.
  - t increments.
- On the transfer with t == ROUNDS-1: go to IDLE and clear t.
- Without w_ready: window, t and w_out hold unchanged.
- Sigma functions:
  - WORD_BITS=32: SSIG0 = ROTR7^ROTR18^SHR3; SSIG1 = ROTR17^ROTR19^SHR10.
  - WORD_BITS=64: SSIG0 = ROTR1^ROTR8^SHR7; SSIG1 = ROTR19^ROTR61^SHR6.
- Expanded words computed for t >= ROUNDS-16 are never emitted; this is harmless.
- blk_valid in RUN is ignored. The source must hold blk_valid until blk_ready.
- Reset values: state=IDLE, t=0, window all zero. Outputs: blk_ready=1, w_valid=0, w_out=0, w_round=0, w_last=0.
- Reset asserted mid-block abandons the block; the first post-reset cycle is IDLE.

## Timing
- Load-to-first-word: block accepted on edge N; w_valid=1 with W[0] from cycle N+1.
- Throughput: one word per cycle while w_ready=1. A block takes ROUNDS cycles in RUN plus 1 IDLE load cycle.
- Back-to-back blocks: the earliest new block is accepted in the cycle after the w_last transfer.
- w_out, w_round, w_last are registered or derived only from state. There is no combinational path from w_ready or blk_valid to any output.
- Critical path: one 4-operand WORD_BITS adder plus sigma XORs.

## Configuration
- SHA_W_SCHEDULE_SCRUB_EN defined:
  - On the w_last transfer, and on reset, all window registers are zeroed, so no message material remains after a block completes.
  - w_out reads 0 in IDLE.
- SHA_W_SCHEDULE_SCRUB_EN undefined:
  - The window retains its last contents in IDLE; only reset zeroes it.
  - w_out in IDLE is don't-care (masked by w_valid=0).

## Test plan
- SHA-256 "abc" padded block (W[0]=0x61626380, W[15]=0x00000018, others 0), w_ready held 1 -> 64 words in 64 consecutive cycles. Required: W[16]=0x61626380, W[17]=0x000F0000, W[63]=0x12B1EDEB, w_last only at w_round=63.
- Same block with w_ready toggled pseudo-randomly -> identical word sequence. w_out and w_round stable during every stall cycle.
- Two blocks, second blk_valid asserted continuously -> second block accepted exactly 1 cycle after the first w_last transfer. blk_ready is 0 throughout RUN.
- reset_n low for 1 cycle at w_round=30 -> next cycle IDLE, w_valid=0, blk_ready=1. A fresh "abc" load yields the correct W[0..63].
- WORD_BITS=64, ROUNDS=80, SHA-512 "abc" block (W[0]=0x6162638000000000, W[15]=0x18) -> W[16]=0x6162638000000000; 80 words emitted; w_last at w_round=79.
- With SHA_W_SCHEDULE_SCRUB_EN: after the w_last transfer, all window registers read 0 and w_out=0 in IDLE. Without the macro, the window retains its values.
